// File: rtl/func_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package func_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Number of input vectors swept for a given input width.
  function automatic int nv_of(input int n_in);
    return 1 << n_in;
  endfunction

  // Width of the hold counter; at least one bit even when HOLD is 1.
  function automatic int ctr_w(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/func_sweep_if.sv
// Command, stimulus and result signals between a sweep controller and the sweeper.
interface func_sweep_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1
);
  import func_sweep_pkg::*;

  localparam int NV = nv_of(N_IN);

  logic                  start;
  logic                  step_mode;
  logic                  step;
  logic [N_OUT-1:0]      f_in;
  logic [NV*N_OUT-1:0]   expect_tbl;
  logic [N_IN-1:0]       vec_out;
  logic                  vec_valid;
  logic [NV*N_OUT-1:0]   table_out;
  logic [N_IN:0]         mismatch_cnt;
  logic [N_IN-1:0]       first_fail;
  logic                  fail;
  logic                  busy;
  logic                  done;

  modport master (
    output start, step_mode, step, f_in, expect_tbl,
    input  vec_out, vec_valid, table_out, mismatch_cnt, first_fail, fail, busy, done
  );

  modport slave (
    input  start, step_mode, step, f_in, expect_tbl,
    output vec_out, vec_valid, table_out, mismatch_cnt, first_fail, fail, busy, done
  );

endinterface

// File: rtl/func_sweep_hold_ctr.sv
// Counts the cycles a vector has been held; last flags the capture cycle.
module func_sweep_hold_ctr
  import func_sweep_pkg::*;
#(
  parameter int HOLD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int            CW       = ctr_w(HOLD);
  localparam logic [CW-1:0] LAST_VAL = CW'(HOLD - 1);

  logic [CW-1:0] cnt;

  // Clear wins over count so a capture restarts the hold window at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/func_sweep.sv
// Exhaustive truth-table sweeper: drives every input vector, captures and
// compares the response against an expected table.
module func_sweep
  import func_sweep_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1,
  parameter int HOLD  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  func_sweep_if.slave  bus
);

  localparam int            NV       = nv_of(N_IN);
  localparam int            IW       = N_IN + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NV - 1);
  localparam logic [IW-1:0] CNT_MAX  = IW'(NV);

  state_t              state;
  state_t              state_nxt;
  logic [IW-1:0]       idx;
  logic                single_step;
  logic                accept;
  logic                capture;
  logic                advance;
  logic                hold_last;
  logic                active;
  int                  slot;
  logic [N_OUT-1:0]    exp_slot;
  logic                slot_bad;
  logic [NV*N_OUT-1:0] cap_tbl;
  logic [IW-1:0]       mis_cnt;
  logic [N_IN-1:0]     first_idx;
  logic                fail_flag;

  func_sweep_hold_ctr #(.HOLD(HOLD)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept | capture),
    .en    (state == S_DRIVE),
    .last  (hold_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus the accept/capture/advance strobes that steer the datapath.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (hold_last) begin
          capture = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = S_DONE;
          end else if (!single_step) begin
            advance = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A start arriving together with step is ignored here; only step matters.
        if (bus.step) begin
          advance   = 1'b1;
          state_nxt = S_DRIVE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Select the expected slot for the vector currently on the DUT.
  always_comb begin
    slot     = int'(idx[N_IN-1:0]);
    exp_slot = bus.expect_tbl[slot*N_OUT +: N_OUT];
    slot_bad = (bus.f_in != exp_slot);
  end

  // Vector index, mode latch, captured table and mismatch bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      single_step <= 1'b0;
      cap_tbl     <= '0;
      mis_cnt     <= '0;
      first_idx   <= '0;
      fail_flag   <= 1'b0;
    end else if (accept) begin
      idx         <= '0;
      single_step <= bus.step_mode;
      cap_tbl     <= '0;
      mis_cnt     <= '0;
      first_idx   <= '0;
      fail_flag   <= 1'b0;
    end else begin
      if (capture) begin
        cap_tbl[slot*N_OUT +: N_OUT] <= bus.f_in;
        if (slot_bad) begin
          if (mis_cnt != CNT_MAX) begin
            mis_cnt <= mis_cnt + 1'b1;
          end
          if (!fail_flag) begin
            first_idx <= idx[N_IN-1:0];
            fail_flag <= 1'b1;
          end
        end
      end
      if (advance) begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign active           = (state == S_DRIVE) || (state == S_WAIT);
  assign bus.vec_out      = active ? idx[N_IN-1:0] : '0;
  assign bus.vec_valid    = active;
  assign bus.busy         = active;
  assign bus.done         = (state == S_DONE);
  assign bus.table_out    = cap_tbl;
  assign bus.mismatch_cnt = mis_cnt;
  assign bus.first_fail   = first_idx;
  assign bus.fail         = fail_flag;

endmodule
